keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Column-scan sequencer for the 4x4 matrix keypad. Drives one column low at a time.
//  Watches the any-key detect flag from key_detector (det high = some debounced row low).
//  Confirms and encodes a keypress into a 4-bit code, then presents it on a valid/ready
//  handshake. Sits between the row debouncers/key_detector and the key consumer (display/FSM).
// PARAMETERS
//  SCAN_DIV  default 50_000  clk cycles each column is held during scanning (>=2)
//  CONFIRM   default 8       consecutive det cycles required to accept press / release (>=1)
// PORTS
//  clk_i        in   1  system clock
//  rst_i        in   1  synchronous reset, active-high
//  det_i        in   1  any-key flag from key_detector (1 = a row of the driven column is low)
//  row_i        in   4  debounced rows, active-low, row_i[0] = row 0
//  col_o        out  4  column drive, active-low one-hot, col_o[0] = column 0
//  key_code_o   out  4  {col_idx[1:0], row_idx[1:0]} of the accepted key
//  key_valid_o  out  1  key_code_o valid; held until accepted
//  key_ready_i  in   1  consumer accepts when key_valid_o && key_ready_i at a rising edge
//  scanning_o   out  1  1 while in ST_SCAN
// BEHAVIOUR
//  Reset: state=ST_SCAN, col_idx=0, col_o=4'b1110, key_code_o=0, key_valid_o=0,
//   scanning_o=1, timer=0. Reset mid-handshake drops valid; the pending code is lost.
//  FSM states: ST_SCAN, ST_CONFIRM, ST_PRESENT, ST_RELEASE.
//  ST_SCAN: timer counts 0..SCAN_DIV-1.
//   - det_i=1 -> ST_CONFIRM, timer=0, column frozen.
//   - Else at SCAN_DIV-1, col_idx+1 (3 wraps to 0) and timer=0.
//   - det_i has priority over the column step in the same cycle.
//  ST_CONFIRM: column frozen.
//   - det_i=0 -> ST_SCAN at the same column, timer=0. Glitch rejected; no code issued.
//   - CONFIRM consecutive det_i=1 cycles -> capture key_code_o={col_idx,row_idx}, go to
//     ST_PRESENT with key_valid_o=1 on the next cycle.
//   - Press-to-valid latency = CONFIRM+1 cycles after det_i first seen.
//  row_idx = lowest index i with row_i[i]=0 (priority encoder). If row_i==4'hF at capture,
//   treat it as a glitch: return to ST_SCAN.
//  ST_PRESENT: key_valid_o=1, key_code_o stable.
//   - key_ready_i=1 -> valid drops next cycle, go to ST_RELEASE.
//   - det_i is ignored here: a release before the ack still delivers the code.
//   - key_ready_i outside ST_PRESENT has no effect.
//  ST_RELEASE: column frozen.
//   - After CONFIRM consecutive det_i=0 cycles -> ST_SCAN, col_idx+1, timer=0.
//   - Any det_i=1 restarts the count. A held key therefore yields exactly one code
//     (no auto-repeat).
//  Timer width = $clog2(max(SCAN_DIV,CONFIRM)+1); no overflow possible.
//  col_o = ~(4'b0001 << col_idx) in every state. col_o is registered: no glitches, and
//   exactly one bit low at all times.
// STRUCTURE
//  keypad_pkg holds:
//   - typedef enum logic [1:0] kp_state_t {ST_SCAN,ST_CONFIRM,ST_PRESENT,ST_RELEASE}
//   - typedef logic [3:0] key_code_t
//   - localparams N_COLS=4, N_ROWS=4
//  Sub-module keypad_row_encoder: combinational row_i -> {hit, row_idx[1:0]} priority encoder.
//  key_detector is instantiated by the parent, not inside this block.
// TESTING (bench: SCAN_DIV=4, CONFIRM=3)
//  1 Reset, no key -> col_o cycles 1110,1101,1011,0111,1110 every 4 clk; valid stays 0.
//  2 Key col2,row1 pressed while col_o=1011 -> det 3 cycles -> valid=1, code=4'b1001;
//    ready=1 -> valid=0 next clk. Release -> scanning resumes at col3 after 3 clk.
//  3 det_i pulses 2 cycles in ST_CONFIRM -> no valid; scanning resumes at the same column.
//  4 Key held 100 clk, ready tied 1 -> exactly one valid pulse, code 4'b1001.
//  5 ready held 0 for 20 clk, key released meanwhile -> valid and code stay stable until ready.
//  6 rst_i=1 during ST_PRESENT -> next clk valid=0, code=0, col_o=1110, scanning_o=1.
//  Assert every cycle: $onehot(~col_o); code stable while valid && !ready.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scan controller
// Purpose: FSM state encoding, key code type, matrix geometry and the column drive helper.
// Ports: none (package).
package keypad_pkg;

    localparam int N_COLS = 4;
    localparam int N_ROWS = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_CONFIRM,
        ST_PRESENT,
        ST_RELEASE
    } kp_state_t;

    typedef logic [3:0] key_code_t;

    // Active-low one-hot column drive for a column index.
    function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(N_COLS'(1) << idx);
    endfunction

endpackage

// File: rtl/keypad_row_encoder.sv
// rtl/keypad_row_encoder.sv - priority encoder for active-low keypad rows
// Purpose: reports whether any row is low and the index of the lowest such row.
// Ports:
//   row_i      in  4  debounced rows, active-low
//   hit_o      out 1  at least one row is low
//   row_idx_o  out 2  lowest row index that is low (0 when hit_o=0)
module keypad_row_encoder
    import keypad_pkg::*;
(
    input  logic [N_ROWS-1:0] row_i,
    output logic              hit_o,
    output logic [1:0]        row_idx_o
);

    // Scan from the top down so the lowest low row is the last one written.
    always_comb begin
        hit_o     = 1'b0;
        row_idx_o = 2'd0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (!row_i[i]) begin
                hit_o     = 1'b1;
                row_idx_o = 2'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press confirm and valid/ready output
// Purpose: steps an active-low column strobe, confirms a press on the frozen column,
//          encodes it and holds it on a valid/ready handshake, then waits for release.
// Ports:
//   clk_i        in  1  system clock
//   rst_i        in  1  synchronous reset, active-high
//   det_i        in  1  any-key flag for the driven column
//   row_i        in  4  debounced rows, active-low
//   col_o        out 4  column drive, active-low one-hot (registered)
//   key_code_o   out 4  {col_idx, row_idx} of the accepted key
//   key_valid_o  out 1  key_code_o valid, held until accepted
//   key_ready_i  in  1  consumer accept
//   scanning_o   out 1  high while scanning columns
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter int CONFIRM  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              det_i,
    input  logic [N_ROWS-1:0] row_i,
    output logic [N_COLS-1:0] col_o,
    output key_code_t         key_code_o,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic              scanning_o
);

    localparam int MAX_CNT = (SCAN_DIV > CONFIRM) ? SCAN_DIV : CONFIRM;
    localparam int TW      = $clog2(MAX_CNT + 1);
    localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] CONF_LAST = TW'(CONFIRM - 1);

    kp_state_t         r_state, w_state;
    logic [TW-1:0]     r_timer, w_timer;
    logic [1:0]        r_col_idx, w_col_idx;
    logic [N_COLS-1:0] r_col;
    key_code_t         r_code, w_code;
    logic              r_valid, w_valid;

    logic              w_hit;
    logic [1:0]        w_row_idx;

    keypad_row_encoder u_row_enc (
        .row_i     (row_i),
        .hit_o     (w_hit),
        .row_idx_o (w_row_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_SCAN;
            r_timer   <= '0;
            r_col_idx <= 2'd0;
            r_col     <= 4'b1110;
            r_code    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_col_idx <= w_col_idx;
            // Drive is registered from the next index so it always matches r_col_idx.
            r_col     <= col_drive(w_col_idx);
            r_code    <= w_code;
            r_valid   <= w_valid;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_col_idx = r_col_idx;
        w_code    = r_code;
        w_valid   = r_valid;
        case (r_state)
            ST_SCAN: begin
                // A detect wins over the column step in the same cycle.
                if (det_i) begin
                    w_state = ST_CONFIRM;
                    w_timer = '0;
                end else if (r_timer == SCAN_LAST) begin
                    w_col_idx = r_col_idx + 2'd1;
                    w_timer   = '0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            ST_CONFIRM: begin
                if (!det_i) begin
                    w_state = ST_SCAN;
                    w_timer = '0;
                end else if (r_timer == CONF_LAST) begin
                    w_timer = '0;
                    // Detect without any low row is treated as a glitch.
                    if (w_hit) begin
                        w_code  = {r_col_idx, w_row_idx};
                        w_valid = 1'b1;
                        w_state = ST_PRESENT;
                    end else begin
                        w_state = ST_SCAN;
                    end
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            ST_PRESENT: begin
                // det_i ignored: an early release still delivers the code.
                if (key_ready_i) begin
                    w_valid = 1'b0;
                    w_state = ST_RELEASE;
                    w_timer = '0;
                end
            end
            ST_RELEASE: begin
                if (det_i) begin
                    w_timer = '0;
                end else if (r_timer == CONF_LAST) begin
                    w_state   = ST_SCAN;
                    w_col_idx = r_col_idx + 2'd1;
                    w_timer   = '0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            default: begin
                w_state = ST_SCAN;
                w_timer = '0;
            end
        endcase
    end

    assign col_o       = r_col;
    assign key_code_o  = r_code;
    assign key_valid_o = r_valid;
    assign scanning_o  = (r_state == ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       det_i;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_ready_i;
    logic       scanning_o;

    int n_vec  = 0;
    int n_fail = 0;

    // Keypad model: the pressed key pulls its row low only while its column is driven.
    logic       key_down;
    logic       force_det;
    logic [1:0] key_col;
    logic [1:0] key_row;
    logic       w_key_hit;

    assign w_key_hit = key_down && (col_o[key_col] == 1'b0);
    assign det_i     = force_det | w_key_hit;
    assign row_i     = w_key_hit ? ~(4'b0001 << key_row) : 4'hF;

    keypad_scan_ctrl #(.SCAN_DIV(4), .CONFIRM(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .det_i       (det_i),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .scanning_o  (scanning_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle properties: one column low, code/valid stable while stalled.
    logic       prev_rst = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [3:0] prev_code = 4'h0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            n_vec++;
            assert ($onehot(~col_o)) else begin
                n_fail++;
                $error("FAIL col_onehot observed=%b expected=one bit low", col_o);
            end
        end
        if (!prev_rst && prev_valid && !prev_ready) begin
            n_vec++;
            assert (key_valid_o === 1'b1 && key_code_o === prev_code) else begin
                n_fail++;
                $error("FAIL stall_stable observed=%b/%h expected=1/%h", key_valid_o, key_code_o, prev_code);
            end
        end
        prev_rst   <= rst_i;
        prev_valid <= key_valid_o;
        prev_ready <= key_ready_i;
        prev_code  <= key_code_o;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    int         n_high;
    logic [3:0] code_seen;
    logic [3:0] exp_col;

    initial begin
        rst_i       = 1'b1;
        key_down    = 1'b0;
        force_det   = 1'b0;
        key_col     = 2'd2;
        key_row     = 2'd1;
        key_ready_i = 1'b0;

        // Reset state
        step();
        step();
        check("rst_col", col_o, 4'b1110);
        check("rst_valid", key_valid_o, 1'b0);
        check("rst_code", key_code_o, 4'h0);
        check("rst_scan", scanning_o, 1'b1);
        rst_i = 1'b0;

        // 1: idle scan, column steps every 4 clocks
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("scan_col", col_o, exp_col);
            check("scan_valid", key_valid_o, 1'b0);
        end

        // 2: press col2,row1, confirm, handshake, release
        key_down = 1'b1;
        repeat (8) step();
        check("t2_col2", col_o, 4'b1011);
        check("t2_scan", scanning_o, 1'b1);
        step();
        check("t2_confirm", scanning_o, 1'b0);
        step();
        step();
        check("t2_not_yet", key_valid_o, 1'b0);
        step();
        check("t2_valid", key_valid_o, 1'b1);
        check("t2_code", key_code_o, 4'b1001);
        check("t2_frozen", col_o, 4'b1011);
        key_ready_i = 1'b1;
        step();
        check("t2_ack", key_valid_o, 1'b0);
        key_ready_i = 1'b0;
        key_down    = 1'b0;
        step();
        step();
        check("t2_rel_wait", scanning_o, 1'b0);
        step();
        check("t2_resume_col", col_o, 4'b0111);
        check("t2_resume_scan", scanning_o, 1'b1);

        // 3: two-cycle detect glitch at col3
        force_det = 1'b1;
        step();
        check("t3_confirm", scanning_o, 1'b0);
        step();
        force_det = 1'b0;
        step();
        check("t3_back", scanning_o, 1'b1);
        check("t3_col", col_o, 4'b0111);
        check("t3_novalid", key_valid_o, 1'b0);
        repeat (3) step();
        check("t3_timer_hold", col_o, 4'b0111);
        step();
        check("t3_timer_step", col_o, 4'b1110);

        // 3b: detect with all rows high at capture is rejected
        force_det = 1'b1;
        repeat (4) step();
        check("t3b_back", scanning_o, 1'b1);
        check("t3b_novalid", key_valid_o, 1'b0);
        check("t3b_col", col_o, 4'b1110);
        force_det = 1'b0;

        // 4: key held 100 clocks with ready tied high -> one code only
        key_down    = 1'b1;
        key_ready_i = 1'b1;
        n_high      = 0;
        code_seen   = 4'h0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (key_valid_o) begin
                n_high++;
                code_seen = key_code_o;
            end
        end
        check("t4_pulses", 8'(n_high), 8'd1);
        check("t4_code", code_seen, 4'b1001);
        key_down = 1'b0;
        repeat (3) step();
        check("t4_resume", col_o, 4'b0111);
        key_ready_i = 1'b0;

        // 5: ready low 20 clocks, key released while waiting
        key_down = 1'b1;
        repeat (15) step();
        check("t5_not_yet", key_valid_o, 1'b0);
        step();
        check("t5_valid", key_valid_o, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) key_down = 1'b0;
            step();
            check("t5_hold_valid", key_valid_o, 1'b1);
            check("t5_hold_code", key_code_o, 4'b1001);
        end
        key_ready_i = 1'b1;
        step();
        check("t5_ack", key_valid_o, 1'b0);
        key_ready_i = 1'b0;
        repeat (3) step();
        check("t5_resume", col_o, 4'b0111);

        // 6: reset while presenting
        key_down = 1'b1;
        repeat (16) step();
        check("t6_valid", key_valid_o, 1'b1);
        rst_i = 1'b1;
        step();
        check("t6_valid0", key_valid_o, 1'b0);
        check("t6_code0", key_code_o, 4'h0);
        check("t6_col", col_o, 4'b1110);
        check("t6_scan", scanning_o, 1'b1);
        rst_i    = 1'b0;
        key_down = 1'b0;
        step();
        check("t6_after", col_o, 4'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
